// File: rtl/press_replayer_if.sv
// rtl/press_replayer_if.sv - press request / replayed button bundle
// Purpose: groups the press request input and the replayed button status
//          outputs of press_replayer into one port.
// Signals:
//   pulse    master->slave  press request, one press per high clock
//   button   slave->master  replayed button level
//   busy     slave->master  high while a window or gap is in progress
//   dropped  slave->master  one-cycle strobe when a press is discarded
//   pending  slave->master  queued presses not yet replayed
interface press_replayer_if #(
  parameter int PEND_W = 2
) ();
  logic              pulse;
  logic              button;
  logic              busy;
  logic              dropped;
  logic [PEND_W-1:0] pending;

  modport master (
    output pulse,
    input  button,
    input  busy,
    input  dropped,
    input  pending
  );

  modport slave (
    input  pulse,
    output button,
    output busy,
    output dropped,
    output pending
  );
endinterface

// File: rtl/press_replayer.sv
// rtl/press_replayer.sv - replays press pulses as held button windows
// Purpose: each accepted press pulse becomes one high window of HOLD_CYCLES
//          clocks followed by at least GAP_CYCLES low clocks, so a downstream
//          edge detector sees exactly one rising edge per press.
// Optional feature macro: PRESS_QUEUE_EN (presses arriving while busy are
//          counted and replayed later; without it they are dropped).
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    press_replayer_if slave: pulse in; button, busy, dropped, pending out
module press_replayer #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  press_replayer_if.slave bus
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             button_q, button_d;
  logic             busy_q, busy_d;
  logic             dropped_q, dropped_d;

  // A press that lands while a window is running and cannot start one now.
  logic             extra_press;
  logic             pend_nz;

`ifdef PRESS_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pending_q, pending_d;

  assign pend_nz = (pending_q != '0);
`else
  assign pend_nz = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    button_d    = button_q;
    dropped_d   = 1'b0;
    extra_press = 1'b0;
`ifdef PRESS_QUEUE_EN
    pending_d   = pending_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.pulse) begin
          state_d  = ST_HIGH;
          cnt_d    = HOLD_LOAD;
          button_d = 1'b1;
        end
      end

      ST_HIGH: begin
        extra_press = bus.pulse;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d  = ST_GAP;
          cnt_d    = GAP_LOAD;
          button_d = 1'b0;
        end
      end

      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d       = cnt_q - CNT_ONE;
          extra_press = bus.pulse;
        end else if (pend_nz || bus.pulse) begin
          // Last gap clock: a queued press or a fresh pulse starts the next
          // window immediately, keeping the period at HOLD+GAP.
          state_d  = ST_HIGH;
          cnt_d    = HOLD_LOAD;
          button_d = 1'b1;
`ifdef PRESS_QUEUE_EN
          // One queued press is consumed; a simultaneous pulse replaces it.
          if (pend_nz && !bus.pulse) begin
            pending_d = pending_q - PEND_ONE;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        button_d = 1'b0;
      end
    endcase

    if (extra_press) begin
`ifdef PRESS_QUEUE_EN
      if (pending_q == PEND_MAX) begin
        dropped_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_ONE;
      end
`else
      dropped_d = 1'b1;
`endif
    end

    // busy is registered alongside button so both change on the same edge.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      button_q  <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      button_q  <= button_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

`ifdef PRESS_QUEUE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign bus.pending = pending_q;
`else
  assign bus.pending = {PEND_W{1'b0}};
`endif

  assign bus.button  = button_q;
  assign bus.busy    = busy_q;
  assign bus.dropped = dropped_q;

endmodule
